// File: rtl/inference_sequencer.sv
// Inference sequencer: starts the classifier network on a button edge or a captured
// frame, waits for its result strobe (bounded by a timeout) and latches the argmax.
module inference_sequencer #(
    parameter int indexWidth    = 4,
    parameter int valueWidth    = 16,
    parameter int timeoutCycles = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  startReq,
    input  logic                  frameToggle,
    input  logic                  autoRun,
    input  logic                  maxValid,
    input  logic [indexWidth-1:0] maxIndex,
    input  logic [valueWidth-1:0] maxValue,
    output logic                  NNreset,
    output logic                  NNvalid,
    output logic [indexWidth-1:0] resultIndex,
    output logic [valueWidth-1:0] resultValue,
    output logic                  resultValid,
    output logic                  busy,
    output logic                  timeoutErr,
    output logic [15:0]           inferCount
);
    localparam int              CntW    = $clog2(timeoutCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(timeoutCycles - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RESET_NN, S_SETTLE, S_START, S_WAIT, S_DONE, S_ERROR
    } state_t;

    state_t                  state_q;
    logic                    pending_q;
    logic                    sync1_q, sync2_q, hist_q;
    logic                    startPrev_q;
    logic [1:0]              fill_q;
    logic [CntW-1:0]         tmoCnt_q;
    logic [indexWidth-1:0]   resultIndex_q;
    logic [valueWidth-1:0]   resultValue_q;
    logic                    resultValid_q;
    logic                    timeoutErr_q;
    logic [15:0]             inferCount_q;

    logic startRise, frameEvt, trigger;

    // The sync chain holds reset values for its first cycles, so events are masked until it has filled.
    assign startRise = startReq & ~startPrev_q;
    assign frameEvt  = (fill_q == 2'd3) & (sync2_q ^ hist_q);
    assign trigger   = startRise | (frameEvt & autoRun);

    assign NNreset     = (state_q == S_RESET_NN);
    assign NNvalid     = (state_q == S_START) | ((state_q == S_WAIT) & ~maxValid);
    assign busy        = (state_q != S_IDLE);
    assign resultIndex = resultIndex_q;
    assign resultValue = resultValue_q;
    assign resultValid = resultValid_q;
    assign timeoutErr  = timeoutErr_q;
    assign inferCount  = inferCount_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pending_q     <= 1'b0;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            hist_q        <= 1'b0;
            startPrev_q   <= 1'b0;
            fill_q        <= 2'd0;
            tmoCnt_q      <= '0;
            resultIndex_q <= '0;
            resultValue_q <= '0;
            resultValid_q <= 1'b0;
            timeoutErr_q  <= 1'b0;
            inferCount_q  <= 16'd0;
        end else begin
            sync1_q     <= frameToggle;
            sync2_q     <= sync1_q;
            hist_q      <= sync2_q;
            startPrev_q <= startReq;
            if (fill_q != 2'd3) fill_q <= fill_q + 2'd1;

            // Triggers outside IDLE are remembered once; DONE overrides this below when it consumes them.
            if (trigger && (state_q != S_IDLE)) pending_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    if (trigger || pending_q) begin
                        state_q       <= S_RESET_NN;
                        pending_q     <= 1'b0;
                        resultValid_q <= 1'b0;
                    end
                end
                S_RESET_NN: state_q <= S_SETTLE;
                S_SETTLE:   state_q <= S_START;
                S_START: begin
                    tmoCnt_q <= '0;
                    state_q  <= S_WAIT;
                end
                S_WAIT: begin
                    if (maxValid) begin
                        resultIndex_q <= maxIndex;
                        resultValue_q <= maxValue;
                        resultValid_q <= 1'b1;
                        timeoutErr_q  <= 1'b0;
                        inferCount_q  <= inferCount_q + 16'd1;
                        state_q       <= S_DONE;
                    end else if (tmoCnt_q == CntLast) begin
                        timeoutErr_q <= 1'b1;
                        state_q      <= S_ERROR;
                    end else begin
                        tmoCnt_q <= tmoCnt_q + CntW'(1);
                    end
                end
                S_DONE: begin
                    if (trigger || pending_q) begin
                        state_q       <= S_RESET_NN;
                        resultValid_q <= 1'b0;
                        pending_q     <= pending_q & trigger;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_ERROR: state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_inference_sequencer.sv
// Bench for inference_sequencer: a timeline model (cycles since trigger) checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_inference_sequencer;
    localparam int IW = 4;
    localparam int VW = 16;
    localparam int T  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1, startReq = 1'b0, frameToggle = 1'b0, autoRun = 1'b0, maxValid = 1'b0;
    logic [IW-1:0] maxIndex = '0;
    logic [VW-1:0] maxValue = '0;
    logic          NNreset, NNvalid, resultValid, busy, timeoutErr;
    logic [IW-1:0] resultIndex;
    logic [VW-1:0] resultValue;
    logic [15:0]   inferCount;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    inference_sequencer #(.indexWidth(IW), .valueWidth(VW), .timeoutCycles(T)) dut (
        .clk(clk), .reset(reset), .startReq(startReq), .frameToggle(frameToggle),
        .autoRun(autoRun), .maxValid(maxValid), .maxIndex(maxIndex), .maxValue(maxValue),
        .NNreset(NNreset), .NNvalid(NNvalid), .resultIndex(resultIndex),
        .resultValue(resultValue), .resultValid(resultValid), .busy(busy),
        .timeoutErr(timeoutErr), .inferCount(inferCount)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: a run is described by its offset from the accepting cycle
    // (1 = network reset, 3 = first valid, >=4 waiting) and how it ended.
    bit            m_known = 0, m_active = 0, m_pend = 0, m_rv = 0, m_tmo = 0;
    int            m_ofs = 0, m_end = 0;
    logic [IW-1:0] m_ri = '0;
    logic [VW-1:0] m_rval = '0;
    logic [15:0]   m_cnt = '0;
    bit            m_prevStart = 0;
    bit [2:0]      m_ft = '0;
    int            m_since = 0;

    always @(negedge clk) begin : model_p
        bit eNNr, eNNv, evt, trig;
        if (m_known) begin
            eNNr = m_active && (m_end == 0) && (m_ofs == 1);
            eNNv = m_active && (m_end == 0) && ((m_ofs == 3) || ((m_ofs >= 4) && !maxValid));
            chk("model_NNreset", NNreset, eNNr);
            chk("model_NNvalid", NNvalid, eNNv);
            chk("model_busy", busy, m_active);
            chk("model_resultIndex", resultIndex, m_ri);
            chk("model_resultValue", resultValue, m_rval);
            chk("model_resultValid", resultValid, m_rv);
            chk("model_timeoutErr", timeoutErr, m_tmo);
            chk("model_inferCount", inferCount, m_cnt);
        end
        if (reset) begin
            m_known = 1; m_active = 0; m_pend = 0; m_rv = 0; m_tmo = 0;
            m_ofs = 0; m_end = 0; m_ri = '0; m_rval = '0; m_cnt = '0;
            m_prevStart = 0; m_ft = '0; m_since = 0;
        end else begin
            // m_ft[k] holds frameToggle from k+1 cycles ago; an event is a change two-to-three cycles back.
            evt  = (m_since >= 3) && (m_ft[1] ^ m_ft[2]);
            trig = (startReq && !m_prevStart) || (evt && autoRun);
            if (!m_active) begin
                if (trig || m_pend) begin
                    m_active = 1; m_ofs = 1; m_end = 0; m_pend = 0; m_rv = 0;
                end
            end else if (m_end == 1) begin
                if (trig || m_pend) begin
                    m_ofs = 1; m_end = 0; m_rv = 0; m_pend = m_pend && trig;
                end else begin
                    m_active = 0;
                end
            end else if (m_end == 2) begin
                m_active = 0;
                if (trig) m_pend = 1;
            end else begin
                if (trig) m_pend = 1;
                if ((m_ofs >= 4) && maxValid) begin
                    m_ri = maxIndex; m_rval = maxValue; m_rv = 1; m_tmo = 0;
                    m_cnt = m_cnt + 16'd1; m_end = 1;
                end else if ((m_ofs >= 4) && (m_ofs - 4 == T - 1)) begin
                    m_tmo = 1; m_end = 2;
                end else begin
                    m_ofs++;
                end
            end
            m_prevStart = startReq;
            m_ft = {m_ft[1:0], frameToggle};
            if (m_since < 3) m_since++;
        end
    end

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_inferCount", inferCount, 0);
        chk("rst_resultValid", resultValid, 0);
        chk("rst_NNvalid", NNvalid, 0);
        repeat (4) tick();

        // Button run: result at t+6, DONE at t+7.
        tick(); startReq = 1'b1;
        @(negedge clk); chk("s1_t0_busy", busy, 0);
        tick(); @(negedge clk); chk("s1_t1_NNreset", NNreset, 1); chk("s1_t1_busy", busy, 1);
        tick(); @(negedge clk); chk("s1_t2_NNreset", NNreset, 0); chk("s1_t2_NNvalid", NNvalid, 0);
        for (int k = 3; k <= 5; k++) begin
            tick(); @(negedge clk); chk("s1_wait_NNvalid", NNvalid, 1);
        end
        tick(); maxValid = 1'b1; maxIndex = 4'd7; maxValue = 16'h0340;
        @(negedge clk); chk("s1_t6_NNvalid", NNvalid, 0);
        tick(); maxValid = 1'b0;
        @(negedge clk);
        chk("s1_t7_resultIndex", resultIndex, 7);
        chk("s1_t7_resultValue", resultValue, 16'h0340);
        chk("s1_t7_resultValid", resultValid, 1);
        chk("s1_t7_inferCount", inferCount, 1);
        tick(); startReq = 1'b0;
        @(negedge clk); chk("s1_t8_idle", busy, 0);

        // Frame-triggered run with autoRun set.
        autoRun = 1'b1;
        tick(); frameToggle = 1'b1;
        tick(); @(negedge clk); chk("s2_f1_busy", busy, 0);
        tick(); @(negedge clk); chk("s2_f2_busy", busy, 0);
        tick(); @(negedge clk); chk("s2_f3_NNreset", NNreset, 1);
        repeat (3) tick();
        maxValid = 1'b1; maxIndex = 4'd3; maxValue = 16'h1234;
        tick(); maxValid = 1'b0;
        @(negedge clk); chk("s2_inferCount", inferCount, 2); chk("s2_resultIndex", resultIndex, 3);
        tick();

        // Frame event ignored without autoRun.
        autoRun = 1'b0;
        tick(); frameToggle = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(); @(negedge clk); chk("s3_no_run_busy", busy, 0);
        end

        // Timeout: WAIT t+4..t+11, ERROR at t+12.
        tick(); startReq = 1'b1;
        repeat (11) tick();
        @(negedge clk); chk("s4_last_wait_NNvalid", NNvalid, 1);
        tick();
        @(negedge clk);
        chk("s4_err_timeoutErr", timeoutErr, 1);
        chk("s4_err_resultValid", resultValid, 0);
        chk("s4_err_resultIndex_held", resultIndex, 3);
        chk("s4_err_resultValue_held", resultValue, 16'h1234);
        chk("s4_err_NNvalid", NNvalid, 0);
        tick(); startReq = 1'b0;
        @(negedge clk); chk("s4_idle_busy", busy, 0); chk("s4_sticky", timeoutErr, 1);

        // Result on the final timeout cycle wins and clears the error.
        tick(); startReq = 1'b1;
        repeat (11) tick();
        maxValid = 1'b1; maxIndex = 4'd9; maxValue = 16'hBEEF;
        @(negedge clk); chk("s5_pre_timeoutErr", timeoutErr, 1);
        tick(); maxValid = 1'b0; startReq = 1'b0;
        @(negedge clk);
        chk("s5_done_timeoutErr", timeoutErr, 0);
        chk("s5_done_resultIndex", resultIndex, 9);
        chk("s5_done_resultValue", resultValue, 16'hBEEF);
        chk("s5_done_inferCount", inferCount, 3);
        repeat (2) tick();

        // Two edges during WAIT give exactly one back-to-back run.
        reset = 1'b1;
        tick(); reset = 1'b0;
        @(negedge clk); chk("s6_rst_inferCount", inferCount, 0); chk("s6_rst_resultIndex", resultIndex, 0);
        repeat (3) tick();
        tick(); startReq = 1'b1;
        repeat (4) tick(); startReq = 1'b0;
        tick(); startReq = 1'b1;
        tick(); startReq = 1'b0;
        tick(); startReq = 1'b1;
        tick(); maxValid = 1'b1; maxIndex = 4'd5; maxValue = 16'h0055;
        tick(); maxValid = 1'b0; startReq = 1'b0;
        @(negedge clk); chk("s6_done1_inferCount", inferCount, 1);
        tick(); @(negedge clk); chk("s6_rerun_NNreset", NNreset, 1); chk("s6_rerun_busy", busy, 1);
        repeat (3) tick();
        maxValid = 1'b1; maxIndex = 4'd6; maxValue = 16'h0066;
        tick(); maxValid = 1'b0;
        @(negedge clk); chk("s6_done2_inferCount", inferCount, 2); chk("s6_done2_resultIndex", resultIndex, 6);
        tick(); @(negedge clk); chk("s6_no_third_run", busy, 0);

        // Reset in WAIT aborts; a late result strobe is ignored.
        tick(); startReq = 1'b1;
        repeat (4) tick(); startReq = 1'b0;
        tick(); reset = 1'b1;
        tick(); reset = 1'b0; maxValid = 1'b1; maxIndex = 4'hF; maxValue = 16'hFFFF;
        @(negedge clk);
        chk("s7_NNreset", NNreset, 0);
        chk("s7_NNvalid", NNvalid, 0);
        chk("s7_busy", busy, 0);
        chk("s7_resultIndex", resultIndex, 0);
        chk("s7_resultValue", resultValue, 0);
        chk("s7_resultValid", resultValid, 0);
        chk("s7_timeoutErr", timeoutErr, 0);
        chk("s7_inferCount", inferCount, 0);
        tick(); maxValid = 1'b0;
        @(negedge clk); chk("s7_after_busy", busy, 0); chk("s7_after_inferCount", inferCount, 0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule

// File: doc/inference_sequencer.md
INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 SHALL have parameter indexWidth, default 4, width of classifier index.
REQ-002 SHALL have parameter valueWidth, default 16, width of classifier max value.
REQ-003 SHALL have parameter timeoutCycles, default 4096, maximum WAIT duration in clk cycles (>=2).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port startReq  input  1  software/button start; rising edge is one trigger.
REQ-007 SHALL have port frameToggle  input  1  asynchronous toggle from serial capture; each transition is one completed frame.
REQ-008 SHALL have port autoRun  input  1  when 1, frame events act as triggers; when 0, frame events are ignored.
REQ-009 SHALL have port maxValid  input  1  network result strobe.
REQ-010 SHALL have port maxIndex  input  indexWidth  network argmax.
REQ-011 SHALL have port maxValue  input  valueWidth  network max score.
REQ-012 SHALL have port NNreset  output  1  network reset pulse.
REQ-013 SHALL have port NNvalid  output  1  network input-valid / run enable.
REQ-014 SHALL have port resultIndex  output  indexWidth  latched argmax.
REQ-015 SHALL have port resultValue  output  valueWidth  latched max score.
REQ-016 SHALL have port resultValid  output  1  latched result is current.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port timeoutErr  output  1  sticky timeout flag.
REQ-019 SHALL have port inferCount  output  16  completed-inference counter.

Function
REQ-020 SHALL implement states IDLE, RESET_NN, SETTLE, START, WAIT, DONE, ERROR.
REQ-021 SHALL synchronize frameToggle through two flops plus one history flop; frame event = sync2 XOR history, 3 cycles after toggle.
REQ-022 SHALL suppress frame events for the first 3 cycles after reset deasserts (pipeline fill).
REQ-023 SHALL form trigger = (startReq rising edge, via registered previous value) OR (frame event AND autoRun).
REQ-024 IDLE: trigger or pending -> RESET_NN next cycle; pending cleared on that transition.
REQ-025 RESET_NN: NNreset=1 for exactly this one cycle; -> SETTLE; resultValid cleared.
REQ-026 SETTLE: both NN outputs 0; -> START.
REQ-027 START: NNvalid=1; -> WAIT; maxValid ignored; timeout counter cleared to 0.
REQ-028 WAIT: NNvalid=1 while maxValid=0 (Mealy); counter increments each cycle.
REQ-029 WAIT with maxValid=1: NNvalid=0 that cycle; resultIndex/resultValue load maxIndex/maxValue at that edge; -> DONE.
REQ-030 WAIT with counter = timeoutCycles-1 and maxValid=0: -> ERROR; maxValid=1 in the same cycle takes priority over timeout.
REQ-031 DONE (one cycle): resultValid=1 from this cycle until next RESET_NN; timeoutErr cleared; inferCount+1 (wraps 0xFFFF->0); -> RESET_NN if pending or trigger, else IDLE.
REQ-032 ERROR (one cycle): timeoutErr=1 (sticky until next DONE or reset); resultValid stays 0; -> IDLE.
REQ-033 Trigger in any state other than IDLE SHALL set a one-deep pending flag; further triggers while pending are dropped.
REQ-034 resultIndex/resultValue SHALL hold last successful result through later runs and errors until overwritten.
REQ-035 maxValid outside WAIT SHALL have no effect.
REQ-036 Trigger-to-NNvalid latency SHALL be 3 cycles (IDLE trigger at t: NNreset at t+1, NNvalid at t+3).

Reset
REQ-037 reset SHALL force, on the next edge: state IDLE, NNreset=0, NNvalid=0, resultIndex=0, resultValue=0, resultValid=0, busy=0, timeoutErr=0, inferCount=0, pending=0, sync/history/startReq-history flops=0.
REQ-038 reset mid-operation (any state) SHALL abort without latching result or counting; reset has priority over all triggers.

Verification
REQ-039 startReq 0->1 at t, maxValid=1 with maxIndex=7, maxValue=0x0340 at t+6 -> NNreset at t+1, NNvalid t+3..t+5, resultIndex=7, resultValue=0x0340, resultValid=1 and inferCount=1 at t+7.
REQ-040 autoRun=1, frameToggle 0->1 -> trigger 3 cycles later, NNreset 1 cycle after; repeat with autoRun=0 -> no activity, busy stays 0.
REQ-041 timeoutCycles=8, start, maxValid never -> ERROR after 8 WAIT cycles, timeoutErr=1, resultValid=0, previous result held; next good run clears timeoutErr.
REQ-042 Two startReq edges during WAIT -> exactly one extra run starts directly from DONE (no IDLE cycle); inferCount ends at 2.
REQ-043 reset asserted in WAIT -> next cycle all outputs at reset values; maxValid=1 afterwards ignored; inferCount=0.
REQ-044 maxValid=1 on final timeout cycle -> DONE, result latched, timeoutErr=0.
